// File: rtl/prf_alloc_queue.sv
// Circular free list of integer physical register indices feeding rename.
// Offers up to WAYS free pregs per cycle and accepts pregs returned at commit.
module prf_alloc_queue #(
  parameter int unsigned PRF_SIZE = 64,
  parameter int unsigned ARF_SIZE = 32,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned IDX      = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [WAYS-1:0]           alloc_req_i,
  output logic [WAYS-1:0][IDX-1:0]  alloc_preg_o,
  output logic [WAYS-1:0]           alloc_valid_o,
  output logic                      allocatable_o,
  input  logic [WAYS-1:0]           commit_valid_i,
  input  logic [WAYS-1:0]           release_valid_i,
  input  logic [WAYS-1:0][IDX-1:0]  release_preg_i,
  input  logic                      recover_i,
  output logic [IDX:0]              free_count_o,
  output logic                      overflow_err_o
);

  typedef logic [IDX:0] ptr_t;

  localparam logic [IDX+1:0] CapWide  = PRF_SIZE[IDX+1:0];
  localparam ptr_t           TailInit = ptr_t'(PRF_SIZE - ARF_SIZE);

  function automatic ptr_t popcnt(input logic [WAYS-1:0] v);
    ptr_t c;
    c = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      c = c + ptr_t'(v[i]);
    end
    return c;
  endfunction

  logic [IDX-1:0] mem_q [PRF_SIZE];
  logic [IDX-1:0] mem_d [PRF_SIZE];
  ptr_t           head_q, head_d;
  ptr_t           arch_head_q, arch_head_d;
  ptr_t           tail_q, tail_d;
  logic           overflow_q, overflow_d;

  ptr_t           free_count;
  ptr_t           offer_k;
  logic [IDX-1:0] offer_idx;
  ptr_t           n_alloc;
  ptr_t           n_rel;
  ptr_t           avail_after;
  logic           rel_overflow;
  ptr_t           wr_ptr;

  assign free_count     = tail_q - head_q;
  assign allocatable_o  = (free_count >= ptr_t'(WAYS));
  assign free_count_o   = free_count;
  assign overflow_err_o = overflow_q;

  // Way i takes the entry after the ones consumed by lower requesting ways.
  always_comb begin
    offer_k       = '0;
    offer_idx     = '0;
    alloc_preg_o  = '0;
    alloc_valid_o = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      offer_idx        = head_q[IDX-1:0] + offer_k[IDX-1:0];
      alloc_preg_o[i]  = mem_q[offer_idx];
      alloc_valid_o[i] = alloc_req_i[i] & (free_count > offer_k);
      offer_k          = offer_k + ptr_t'(alloc_req_i[i]);
    end
  end

  always_comb begin
    n_alloc     = (allocatable_o && !recover_i) ? popcnt(alloc_req_i) : '0;
    arch_head_d = arch_head_q + popcnt(commit_valid_i);
    // Recover rewinds to the committed head, including this cycle's commits.
    head_d      = recover_i ? arch_head_d : head_q + n_alloc;

    avail_after  = tail_q - head_d;
    n_rel        = popcnt(release_valid_i);
    rel_overflow = ({1'b0, avail_after} + {1'b0, n_rel}) > CapWide;
    overflow_d   = overflow_q | rel_overflow;

    mem_d  = mem_q;
    wr_ptr = tail_q;
    if (!rel_overflow) begin
      for (int i = 0; i < int'(WAYS); i++) begin
        if (release_valid_i[i]) begin
          mem_d[wr_ptr[IDX-1:0]] = release_preg_i[i];
          wr_ptr                 = wr_ptr + ptr_t'(1);
        end
      end
    end
    tail_d = wr_ptr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= TailInit;
      overflow_q  <= 1'b0;
      for (int i = 0; i < int'(PRF_SIZE); i++) begin
        mem_q[i] <= (i < int'(PRF_SIZE - ARF_SIZE)) ? IDX'(int'(ARF_SIZE) + i) : '0;
      end
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_prf_alloc_queue.sv
// Bench for prf_alloc_queue: directed scenarios plus random traffic against a
// queue-based model of the free list and the in-flight (uncommitted) allocations.
module tb_prf_alloc_queue;

  logic            clk;
  logic            rst_ni;
  logic [3:0]      alloc_req;
  logic [3:0][5:0] alloc_preg;
  logic [3:0]      alloc_valid;
  logic            allocatable;
  logic [3:0]      commit_valid;
  logic [3:0]      release_valid;
  logic [3:0][5:0] release_preg;
  logic            recover;
  logic [6:0]      free_count;
  logic            overflow_err;

  int n_checks = 0;
  int n_errors = 0;

  int free_q[$];
  int infl_q[$];
  bit ovf_m;

  prf_alloc_queue #(
    .PRF_SIZE(64),
    .ARF_SIZE(32),
    .WAYS    (4),
    .IDX     (6)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .alloc_req_i    (alloc_req),
    .alloc_preg_o   (alloc_preg),
    .alloc_valid_o  (alloc_valid),
    .allocatable_o  (allocatable),
    .commit_valid_i (commit_valid),
    .release_valid_i(release_valid),
    .release_preg_i (release_preg),
    .recover_i      (recover),
    .free_count_o   (free_count),
    .overflow_err_o (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    infl_q.delete();
    for (int i = 32; i < 64; i++) free_q.push_back(i);
    ovf_m = 1'b0;
  endtask

  task automatic idle_inputs();
    alloc_req     = '0;
    commit_valid  = '0;
    release_valid = '0;
    release_preg  = '0;
    recover       = 1'b0;
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [3:0] req, input logic [3:0] com, input logic [3:0] rel,
                       input logic [3:0][5:0] rp, input logic rec);
    int fc, k, nrel;
    logic [3:0] exp_v;
    alloc_req     = req;
    commit_valid  = com;
    release_valid = rel;
    release_preg  = rp;
    recover       = rec;
    @(negedge clk);
    fc = free_q.size();
    check("free_count", free_count, fc);
    check("allocatable", allocatable, (fc >= 4) ? 1 : 0);
    check("overflow_err", overflow_err, ovf_m);
    k = 0;
    exp_v = '0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if (k < fc) begin
          exp_v[i] = 1'b1;
          check($sformatf("alloc_preg%0d", i), alloc_preg[i], free_q[k]);
        end
        k++;
      end
    end
    check("alloc_valid", alloc_valid, exp_v);
    @(posedge clk);
    for (int c = 0; c < $countones(com); c++) begin
      if (infl_q.size() > 0) void'(infl_q.pop_front());
    end
    if (rec) begin
      while (infl_q.size() > 0) free_q.push_front(infl_q.pop_back());
    end else if (fc >= 4) begin
      for (int n = 0; n < $countones(req); n++) infl_q.push_back(free_q.pop_front());
    end
    nrel = $countones(rel);
    if (free_q.size() + nrel > 64) begin
      ovf_m = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) if (rel[i]) free_q.push_back(int'(rp[i]));
    end
    #1;
  endtask

  task automatic random_cycle();
    logic [3:0]      req, com, rel;
    logic [3:0][5:0] rp;
    logic            rec;
    req = 4'($urandom);
    com = 4'($urandom);
    while ($countones(com) > infl_q.size()) com = com & (com - 4'd1);
    rel = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
    for (int i = 0; i < 4; i++) rp[i] = 6'($urandom);
    rec = ($urandom_range(0, 15) == 0);
    cycle(req, com, rel, rp, rec);
  endtask

  initial begin
    logic [3:0][5:0] rp;
    logic [3:0][5:0] exp_pregs;
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Reset state and first full-width allocation.
    alloc_req = 4'b1111;
    #1;
    exp_pregs = {6'd35, 6'd34, 6'd33, 6'd32};
    check("rst_free_count", free_count, 32);
    check("rst_allocatable", allocatable, 1);
    check("rst_alloc_preg", alloc_preg, exp_pregs);
    check("rst_alloc_valid", alloc_valid, 4'b1111);
    check("rst_overflow", overflow_err, 0);
    @(posedge clk);
    #1;
    // Undo the edge just taken so the model stays aligned.
    do_reset();
    rp = '0;
    cycle(4'b1111, 4'b0000, 4'b0000, rp, 1'b0);
    exp_pregs = {6'd39, 6'd38, 6'd37, 6'd36};
    alloc_req = 4'b1111;
    #1;
    check("alloc4_free_count", free_count, 28);
    check("alloc4_next_pregs", alloc_preg, exp_pregs);

    // Sparse request mask.
    do_reset();
    cycle(4'b1010, 4'b0000, 4'b0000, rp, 1'b0);
    check("sparse_free_count", free_count, 30);

    // Drain to empty, then release two pregs into the empty list.
    do_reset();
    repeat (8) cycle(4'b1111, 4'b0000, 4'b0000, rp, 1'b0);
    check("drain_free_count", free_count, 0);
    check("drain_allocatable", allocatable, 0);
    rp = '0;
    rp[0] = 6'd5;
    rp[2] = 6'd9;
    cycle(4'b1111, 4'b0000, 4'b0101, rp, 1'b0);
    alloc_req = 4'b1111;
    #1;
    check("refill_free_count", free_count, 2);
    check("refill_preg0", alloc_preg[0], 5);
    check("refill_preg1", alloc_preg[1], 9);
    rp = '0;
    cycle(4'b1111, 4'b0000, 4'b0000, rp, 1'b0);
    check("stall_free_count", free_count, 2);

    // Recover with same-cycle commits and an ignored same-cycle alloc.
    do_reset();
    cycle(4'b1111, 4'b0000, 4'b0000, rp, 1'b0);
    cycle(4'b1111, 4'b1111, 4'b0000, rp, 1'b0);
    cycle(4'b1111, 4'b0000, 4'b0000, rp, 1'b0);
    cycle(4'b1111, 4'b0011, 4'b0000, rp, 1'b1);
    check("recover_free_count", free_count, 26);

    // Steady alloc/release so the tail wraps past the end of the array.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 4; i++) rp[i] = 6'($urandom);
      cycle(4'b1111, (c > 0) ? 4'b1111 : 4'b0000, 4'b1111, rp, 1'b0);
    end
    check("wrap_free_count", free_count, 32);

    // Fill to capacity, then overflow by one.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) rp[i] = 6'(c * 4 + i);
      cycle(4'b0000, 4'b0000, 4'b1111, rp, 1'b0);
    end
    check("full_free_count", free_count, 64);
    cycle(4'b0000, 4'b0000, 4'b0001, rp, 1'b0);
    check("ovf_set", overflow_err, 1);
    check("ovf_free_count", free_count, 64);
    cycle(4'b0000, 4'b0000, 4'b0000, rp, 1'b0);
    check("ovf_sticky", overflow_err, 1);

    // Random traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        alloc_req = 4'b1111;
        #2;
        rst_ni = 1'b0;
        #1;
        exp_pregs = {6'd35, 6'd34, 6'd33, 6'd32};
        check("async_rst_free_count", free_count, 32);
        check("async_rst_overflow", overflow_err, 0);
        check("async_rst_pregs", alloc_preg, exp_pregs);
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
      end
      random_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prf_alloc_queue.md
Name: prf_alloc_queue

Overview:
- Circular free-list queue of integer physical register indices. Sits directly upstream of the rename RAT.
- Supplies up to WAYS free pregs per cycle for destination renaming and accepts pregs freed at commit.
- Keeps a committed (architectural) head pointer so a branch-mispredict recover can restore the speculative head in one cycle.

Parameters:
- PRF_SIZE, 64, number of integer physical registers (power of 2).
- ARF_SIZE, 32, number of architectural integer registers; pregs 0..ARF_SIZE-1 are mapped at reset.
- WAYS, 4, rename/commit width.
- IDX, 6, log2(PRF_SIZE), width of a preg index.

Ports:
- clock, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- alloc_req, input, WAYS, per-way rename destination request mask (RAT fl_used).
- alloc_preg, output, WAYS x IDX, preg offered to each way (RAT FL).
- alloc_valid, output, WAYS, alloc_preg[i] is backed by a real free entry (RAT fl_n).
- allocatable, output, 1, free_count >= WAYS.
- commit_valid, input, WAYS, a committing instruction had consumed a preg; advances the architectural head.
- release_valid, input, WAYS, a stale preg is returned this cycle.
- release_preg, input, WAYS x IDX, index of the returned preg.
- recover, input, 1, mispredict flush; restore the speculative head.
- free_count, output, IDX+1, current occupancy (tail - head).
- overflow_err, output, 1, sticky; a release exceeded capacity.

Behaviour:
- Storage: PRF_SIZE x IDX entry array.
- Pointers:
  - head, arch_head and tail are each IDX+1 bits (wrap bit plus index).
  - Pointer arithmetic is modulo 2^(IDX+1).
  - free_count = tail - head.
- Reset (async, reset=0):
  - entry[i] = ARF_SIZE+i for i < PRF_SIZE-ARF_SIZE, other entries = 0.
  - head = arch_head = 0, tail = PRF_SIZE-ARF_SIZE, overflow_err = 0.
  - Resulting outputs: free_count = 32, allocatable = 1, alloc_preg = {32,33,34,35}, alloc_valid = 4'b1111.
- Offer (combinational from registered state only):
  - Let k_i = popcount(alloc_req[i-1:0]).
  - alloc_preg[i] = entry[head + k_i], and alloc_valid[i] = alloc_req[i] & (free_count > k_i).
  - Pregs released in the current cycle are never offered in the same cycle.
- Allocate:
  - If allocatable=1 and recover=0, head += popcount(alloc_req) at the edge.
  - If allocatable=0, head is unchanged regardless of alloc_req; the RAT stalls.
- Release:
  - Valid ways are written in ascending way order, compressed, at tail, tail+1, and so on.
  - tail += popcount(release_valid).
  - If free_count_after_alloc + nrel > PRF_SIZE: set overflow_err, drop the whole release group, and leave tail unchanged.
- Commit: arch_head += popcount(commit_valid) every cycle, independent of recover.
- Recover:
  - head <= arch_head + popcount(commit_valid); this includes the same-cycle commits.
  - Any alloc in the same cycle is ignored.
  - Releases in the same cycle are still applied.
- Simultaneous alloc and release: new free_count = old - nalloc + nrel.
  - Wrap-around is transparent: index = pointer[IDX-1:0].
- Full: free_count == PRF_SIZE is legal. Empty: free_count == 0 gives alloc_valid = 0 and allocatable = 0.
- Latency:
  - Alloc, release and recover effects are visible on outputs the cycle after the edge.
  - No outputs are registered beyond the state above.
- Illegal inputs:
  - commit beyond head: behaviour undefined, no check.
  - overflow_err clears only on reset.

Test Plan:
- Reset, then alloc_req=4'b1111 for one cycle -> that cycle alloc_preg = {32,33,34,35}; next cycle alloc_preg = {36,37,38,39}, free_count = 28.
- alloc_req=4'b1010 from reset -> alloc_preg[1] = 32, alloc_preg[3] = 33, alloc_valid = 4'b1010; next cycle head = 2, free_count = 30.
- Drain with 8 cycles of 4'b1111 -> free_count = 0, allocatable = 0. Then release_valid=4'b0101 with pregs {5,9} -> next cycle free_count = 2, entry[32] = 5, entry[33] = 9; alloc_req=4'b1111 produces no head movement.
- Allocate 12 from reset, commit_valid=4'b0011 in the same cycle as recover=1 (arch_head was 4) -> head = 6, free_count = 26, and the same-cycle alloc is ignored.
- Wrap: cycle alloc and release 4 per cycle for 20 cycles -> tail crosses 64 -> 0. Offered indices follow the released sequence and free_count stays 32.
- At free_count = 64, release 1 preg -> overflow_err = 1 and stays 1, tail unchanged. Assert reset=0 mid-traffic -> all state returns immediately to reset values without waiting for a clock edge.
